// File: rtl/stream_descrambler.sv
// Receive-side additive descrambler: XORs each word with a Galois LFSR keystream that
// reseeds on start-of-frame, tracks frame length and reports loss of frame sync.
module stream_descrambler #(
  parameter int            N         = 16,
  parameter int            W         = 16,
  parameter logic [W-1:0]  POLY      = 16'hB400,
  parameter logic [W-1:0]  SEED      = 16'hACE1,
  parameter int            FRAME_LEN = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic         in_sof,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_sof,
  output logic         locked,
  output logic         sync_err,
  output logic [15:0]  drop_cnt
);

  localparam int            CW = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] FL = CW'(FRAME_LEN);

  typedef enum logic {HUNT, RUN} state_t;

  state_t        state, state_next;
  logic [W-1:0]  lfsr, lfsr_next;
  logic [CW-1:0] cnt, cnt_next;
  logic          accept, pass, drop, overrun;
  logic [N-1:0]  ks;

  function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] s);
    return (s >> 1) ^ (s[0] ? POLY : '0);
  endfunction

  // Valid/ready: a word moves when valid & ready on that side. The single output register
  // may be refilled in the same cycle it drains, so in_ready looks only at the output side.
  assign in_ready = !out_valid | out_ready;
  assign accept   = in_valid & in_ready;
  assign locked   = (state == RUN);

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    lfsr_next  = lfsr;
    pass       = 1'b0;
    drop       = 1'b0;
    overrun    = 1'b0;
    ks         = in_sof ? SEED[N-1:0] : lfsr[N-1:0];
    if (accept) begin
      if (in_sof) begin
        pass       = 1'b1;
        state_next = RUN;
        cnt_next   = CW'(1);
        lfsr_next  = lfsr_step(SEED);
      end else if (state == RUN && cnt < FL) begin
        pass      = 1'b1;
        cnt_next  = cnt + 1'b1;
        lfsr_next = lfsr_step(lfsr);
      end else begin
        // Non-SOF word in HUNT, or one word past the maximum frame length in RUN.
        drop = 1'b1;
        if (state == RUN) begin
          overrun    = 1'b1;
          state_next = HUNT;
          cnt_next   = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HUNT;
      lfsr      <= SEED;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sof   <= 1'b0;
      sync_err  <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      state    <= state_next;
      lfsr     <= lfsr_next;
      cnt      <= cnt_next;
      sync_err <= overrun;
      if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      if (pass) begin
        out_valid <= 1'b1;
        out_data  <= in_data ^ ks;
        out_sof   <= in_sof;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_descrambler.sv
// Bench for stream_descrambler: one instance with default parameters, one with a 4-word frame.
module tb_stream_descrambler;

  localparam logic [15:0] POLY = 16'hB400;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid [2];
  logic        in_sof   [2];
  logic        out_ready[2];
  logic        in_ready [2];
  logic        out_valid[2];
  logic        out_sof  [2];
  logic        locked   [2];
  logic        sync_err [2];
  logic [15:0] in_data  [2];
  logic [15:0] out_data [2];
  logic [15:0] drop_cnt [2];

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: frame position, lock flag, drop count and a queue of pending words.
  int          fl[2] = '{64, 4};
  bit          m_ov[2], m_locked[2], m_serr[2];
  int          m_pos[2], m_drops[2];
  logic [16:0] exp_q[$];
  logic        obs_rdy, exp_rdy;

  always #5 clk = ~clk;

  stream_descrambler dut_d (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]), .in_sof(in_sof[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]), .out_sof(out_sof[0]),
    .locked(locked[0]), .sync_err(sync_err[0]), .drop_cnt(drop_cnt[0])
  );

  stream_descrambler #(.FRAME_LEN(4)) dut_s (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]), .in_sof(in_sof[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]), .out_sof(out_sof[1]),
    .locked(locked[1]), .sync_err(sync_err[1]), .drop_cnt(drop_cnt[1])
  );

  // Keystream for the word at position k of a frame (k = 0 is the SOF word).
  function automatic logic [15:0] ks_at(input int k);
    logic [15:0] s;
    s = SEED;
    for (int j = 0; j < k; j++) s = (s >> 1) ^ (s[0] ? POLY : 16'h0000);
    return s;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    in_valid[0] = 1'b0;
    in_valid[1] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 2; i++) begin
      m_ov[i] = 0; m_locked[i] = 0; m_serr[i] = 0; m_pos[i] = 0; m_drops[i] = 0;
    end
  endtask

  // Drive one clock cycle on instance i and advance the model; returns #1 after the edge.
  task automatic cycle(input int i, input bit v, input bit sof, input logic [15:0] d, input bit ordy);
    in_valid[i] = v; in_sof[i] = sof; in_data[i] = d; out_ready[i] = ordy;
    #1;
    obs_rdy = in_ready[i];
    exp_rdy = !m_ov[i] || ordy;
    m_serr[i] = 0;
    if (m_ov[i] && ordy) begin
      void'(exp_q.pop_front());
      m_ov[i] = 0;
    end
    if (v && exp_rdy) begin
      if (sof) begin
        exp_q.push_back({1'b1, d ^ ks_at(0)});
        m_ov[i] = 1; m_pos[i] = 1; m_locked[i] = 1;
      end else if (m_locked[i] && m_pos[i] < fl[i]) begin
        exp_q.push_back({1'b0, d ^ ks_at(m_pos[i])});
        m_ov[i] = 1; m_pos[i]++;
      end else begin
        if (m_drops[i] < 65535) m_drops[i]++;
        if (m_locked[i]) begin
          m_serr[i] = 1; m_locked[i] = 0;
        end
      end
    end
    @(posedge clk); #1;
    in_valid[i] = 1'b0;
    in_sof[i]   = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      vectors += 6;
      if (out_valid[i] !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid[%0d]: got %b want 0", i, out_valid[i]); end
      if (out_data[i] !== 16'h0000) begin miscompares++; $display("FAIL reset_out_data[%0d]: got %h want 0000", i, out_data[i]); end
      if (out_sof[i] !== 1'b0) begin miscompares++; $display("FAIL reset_out_sof[%0d]: got %b want 0", i, out_sof[i]); end
      if (locked[i] !== 1'b0) begin miscompares++; $display("FAIL reset_locked[%0d]: got %b want 0", i, locked[i]); end
      if (sync_err[i] !== 1'b0) begin miscompares++; $display("FAIL reset_sync_err[%0d]: got %b want 0", i, sync_err[i]); end
      if (drop_cnt[i] !== 16'h0000) begin miscompares++; $display("FAIL reset_drop_cnt[%0d]: got %h want 0000", i, drop_cnt[i]); end
    end
  endtask

  task automatic test_basic();
    logic [15:0] din[3], dexp[3];
    din  = '{16'hAAAA, 16'h00FF, 16'h0F0F};
    dexp = '{16'h064B, 16'hE28F, 16'h7E37};
    do_reset();
    for (int k = 0; k < 3; k++) begin
      cycle(0, 1, k == 0, din[k], 1);
      vectors += 4;
      if (out_valid[0] !== 1'b1) begin miscompares++; $display("FAIL basic_valid[%0d]: got %b want 1", k, out_valid[0]); end
      if (out_data[0] !== dexp[k]) begin miscompares++; $display("FAIL basic_data[%0d]: got %h want %h", k, out_data[0], dexp[k]); end
      if (out_sof[0] !== (k == 0)) begin miscompares++; $display("FAIL basic_sof[%0d]: got %b want %b", k, out_sof[0], k == 0); end
      if (locked[0] !== 1'b1) begin miscompares++; $display("FAIL basic_locked[%0d]: got %b want 1", k, locked[0]); end
    end
    cycle(0, 0, 0, 16'h0000, 1);
    vectors++;
    if (out_valid[0] !== 1'b0) begin miscompares++; $display("FAIL basic_idle_valid: got %b want 0", out_valid[0]); end
  endtask

  task automatic test_hunt_drop();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      cycle(0, 1, 0, 16'($urandom), 1);
      vectors += 2;
      if (out_valid[0] !== 1'b0) begin miscompares++; $display("FAIL hunt_valid[%0d]: got %b want 0", k, out_valid[0]); end
      if (locked[0] !== 1'b0) begin miscompares++; $display("FAIL hunt_locked[%0d]: got %b want 0", k, locked[0]); end
    end
    vectors++;
    if (drop_cnt[0] !== 16'd3) begin miscompares++; $display("FAIL hunt_drop_cnt: got %0d want 3", drop_cnt[0]); end
    cycle(0, 1, 1, 16'hAAAA, 1);
    vectors += 2;
    if (out_valid[0] !== 1'b1) begin miscompares++; $display("FAIL hunt_sof_valid: got %b want 1", out_valid[0]); end
    if (out_data[0] !== 16'h064B) begin miscompares++; $display("FAIL hunt_sof_data: got %h want 064b", out_data[0]); end
    cycle(0, 0, 0, 16'h0000, 1);
  endtask

  task automatic test_backpressure();
    do_reset();
    cycle(0, 1, 1, 16'hAAAA, 1);
    cycle(0, 1, 0, 16'h00FF, 1);
    for (int k = 0; k < 4; k++) begin
      cycle(0, 1, 0, 16'h0F0F, 0);
      vectors += 3;
      if (obs_rdy !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready[%0d]: got %b want 0", k, obs_rdy); end
      if (out_valid[0] !== 1'b1) begin miscompares++; $display("FAIL bp_valid[%0d]: got %b want 1", k, out_valid[0]); end
      if (out_data[0] !== 16'hE28F) begin miscompares++; $display("FAIL bp_hold[%0d]: got %h want e28f", k, out_data[0]); end
    end
    cycle(0, 1, 0, 16'h0F0F, 1);
    vectors += 2;
    if (obs_rdy !== 1'b1) begin miscompares++; $display("FAIL bp_release_ready: got %b want 1", obs_rdy); end
    if (out_data[0] !== 16'h7E37) begin miscompares++; $display("FAIL bp_after_w2: got %h want 7e37", out_data[0]); end
    cycle(0, 1, 0, 16'h1234, 1);
    vectors++;
    if (out_data[0] !== 16'h2AA8) begin miscompares++; $display("FAIL bp_after_w3: got %h want 2aa8", out_data[0]); end
    cycle(0, 0, 0, 16'h0000, 1);
  endtask

  task automatic test_overrun();
    logic [15:0] din[4], dexp[4];
    din  = '{16'hAAAA, 16'h00FF, 16'h0F0F, 16'h1234};
    dexp = '{16'h064B, 16'hE28F, 16'h7E37, 16'h2AA8};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      cycle(1, 1, k == 0, din[k], 1);
      vectors += 2;
      if (out_data[1] !== dexp[k]) begin miscompares++; $display("FAIL ovr_data[%0d]: got %h want %h", k, out_data[1], dexp[k]); end
      if (sync_err[1] !== 1'b0) begin miscompares++; $display("FAIL ovr_early_err[%0d]: got %b want 0", k, sync_err[1]); end
    end
    cycle(1, 1, 0, 16'h5555, 1);
    vectors += 4;
    if (out_valid[1] !== 1'b0) begin miscompares++; $display("FAIL ovr_valid: got %b want 0", out_valid[1]); end
    if (sync_err[1] !== 1'b1) begin miscompares++; $display("FAIL ovr_sync_err: got %b want 1", sync_err[1]); end
    if (locked[1] !== 1'b0) begin miscompares++; $display("FAIL ovr_locked: got %b want 0", locked[1]); end
    if (drop_cnt[1] !== 16'd1) begin miscompares++; $display("FAIL ovr_drop_cnt: got %0d want 1", drop_cnt[1]); end
    cycle(1, 0, 0, 16'h0000, 1);
    vectors++;
    if (sync_err[1] !== 1'b0) begin miscompares++; $display("FAIL ovr_pulse_width: got %b want 0", sync_err[1]); end
    cycle(1, 1, 1, 16'hAAAA, 1);
    vectors += 2;
    if (out_data[1] !== 16'h064B) begin miscompares++; $display("FAIL ovr_resync_data: got %h want 064b", out_data[1]); end
    if (locked[1] !== 1'b1) begin miscompares++; $display("FAIL ovr_resync_locked: got %b want 1", locked[1]); end
    cycle(1, 0, 0, 16'h0000, 1);
  endtask

  task automatic test_early_sof();
    logic [15:0] dexp[3];
    bit          sofs[3];
    dexp = '{16'h064B, 16'hE28F, 16'h064B};
    sofs = '{1'b1, 1'b0, 1'b1};
    do_reset();
    for (int k = 0; k < 3; k++) begin
      cycle(0, 1, sofs[k], (k == 1) ? 16'h00FF : 16'hAAAA, 1);
      vectors += 3;
      if (out_data[0] !== dexp[k]) begin miscompares++; $display("FAIL early_data[%0d]: got %h want %h", k, out_data[0], dexp[k]); end
      if (out_sof[0] !== sofs[k]) begin miscompares++; $display("FAIL early_sof[%0d]: got %b want %b", k, out_sof[0], sofs[k]); end
      if (sync_err[0] !== 1'b0) begin miscompares++; $display("FAIL early_sync_err[%0d]: got %b want 0", k, sync_err[0]); end
    end
    cycle(0, 0, 0, 16'h0000, 1);
  endtask

  task automatic test_reset_mid();
    do_reset();
    cycle(0, 1, 1, 16'hAAAA, 0);
    vectors++;
    if (out_valid[0] !== 1'b1) begin miscompares++; $display("FAIL rmid_pending: got %b want 1", out_valid[0]); end
    do_reset();
    vectors += 3;
    if (out_valid[0] !== 1'b0) begin miscompares++; $display("FAIL rmid_valid: got %b want 0", out_valid[0]); end
    if (locked[0] !== 1'b0) begin miscompares++; $display("FAIL rmid_locked: got %b want 0", locked[0]); end
    if (drop_cnt[0] !== 16'd0) begin miscompares++; $display("FAIL rmid_drop_cnt: got %0d want 0", drop_cnt[0]); end
    cycle(0, 1, 0, 16'h3C3C, 1);
    vectors += 2;
    if (out_valid[0] !== 1'b0) begin miscompares++; $display("FAIL rmid_drop_valid: got %b want 0", out_valid[0]); end
    if (drop_cnt[0] !== 16'd1) begin miscompares++; $display("FAIL rmid_drop_cnt2: got %0d want 1", drop_cnt[0]); end
  endtask

  task automatic test_random(input int i, input int n, input int sof_odds);
    logic [16:0] h;
    do_reset();
    for (int k = 0; k < n + 2; k++) begin
      if (k < n) cycle(i, $urandom_range(0, 3) != 0, $urandom_range(0, sof_odds - 1) == 0, 16'($urandom), $urandom_range(0, 3) != 0);
      else cycle(i, 0, 0, 16'h0000, 1);
      vectors += 5;
      if (obs_rdy !== exp_rdy) begin miscompares++; $display("FAIL rnd_in_ready[%0d,%0d]: got %b want %b", i, k, obs_rdy, exp_rdy); end
      if (out_valid[i] !== m_ov[i]) begin miscompares++; $display("FAIL rnd_valid[%0d,%0d]: got %b want %b", i, k, out_valid[i], m_ov[i]); end
      if (locked[i] !== m_locked[i]) begin miscompares++; $display("FAIL rnd_locked[%0d,%0d]: got %b want %b", i, k, locked[i], m_locked[i]); end
      if (sync_err[i] !== m_serr[i]) begin miscompares++; $display("FAIL rnd_sync_err[%0d,%0d]: got %b want %b", i, k, sync_err[i], m_serr[i]); end
      if (drop_cnt[i] !== 16'(m_drops[i])) begin miscompares++; $display("FAIL rnd_drop_cnt[%0d,%0d]: got %0d want %0d", i, k, drop_cnt[i], m_drops[i]); end
      if (m_ov[i] && exp_q.size() > 0) begin
        h = exp_q[0];
        vectors += 2;
        if (out_data[i] !== h[15:0]) begin miscompares++; $display("FAIL rnd_data[%0d,%0d]: got %h want %h", i, k, out_data[i], h[15:0]); end
        if (out_sof[i] !== h[16]) begin miscompares++; $display("FAIL rnd_sof[%0d,%0d]: got %b want %b", i, k, out_sof[i], h[16]); end
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0; in_sof[i] = 1'b0; in_data[i] = 16'h0000; out_ready[i] = 1'b1;
    end
    test_reset();
    test_basic();
    test_hunt_drop();
    test_backpressure();
    test_overrun();
    test_early_sof();
    test_reset_mid();
    test_random(0, 2000, 50);
    test_random(1, 1500, 5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
